// File: rtl/id_stage.sv
// Purpose: Octa16 decode/operand-fetch stage with 8x8 register file, pending-write scoreboard and writeback bypass.
// Latency: 1 cycle, so an instruction accepted at edge N is on ex_* right after edge N. Full throughput when ex_ready=1.
// Backpressure: instr_ready drops while the ex register is held (ex_valid && !ex_ready) or a RAW/WAW hazard is pending.
module id_stage #(
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [7:0]  ex_rs1,
  output logic [7:0]  ex_rs2,
  output logic [2:0]  ex_ctrl,
  output logic        ex_flag,
  output logic [2:0]  ex_rd,
  output logic        ex_li,
  output logic [7:0]  ex_imm,
  input  logic        wb_en,
  input  logic [2:0]  wb_rd,
  input  logic [7:0]  wb_data,
  output logic        illegal
);

  localparam logic [2:0] CTRL_LI = 3'b111;

  // Architectural state
  logic [7:0] rf_q [8];
  logic [7:0] pend_q, pend_d;

  // Execute-stage register
  logic       ex_valid_q, ex_valid_d;
  logic [7:0] ex_rs1_q, ex_rs1_d;
  logic [7:0] ex_rs2_q, ex_rs2_d;
  logic [2:0] ex_ctrl_q, ex_ctrl_d;
  logic       ex_flag_q, ex_flag_d;
  logic [2:0] ex_rd_q, ex_rd_d;
  logic       ex_li_q, ex_li_d;
  logic [7:0] ex_imm_q, ex_imm_d;
  logic       illegal_q, illegal_d;

  // Decode fields
  logic [2:0] dec_ctrl, dec_rd, dec_rs1, dec_rs2;
  logic       dec_flag, dec_li, dec_ill;
  logic [7:0] wb_clr, busy;
  logic       hazard, fire, issue, rf_we;
  logic [7:0] rs1_val, rs2_val;

  // Split the instruction word into its fields and classify the opcode
  always_comb begin
    dec_ctrl = instr[15:13];
    dec_flag = instr[12];
    dec_rd   = instr[11:9];
    dec_rs1  = instr[8:6];
    dec_rs2  = instr[5:3];
    dec_li   = (dec_ctrl == CTRL_LI);
    dec_ill  = (dec_ctrl == 3'b101) || (dec_ctrl == 3'b110);
  end

  // A register is busy if pending and not being written back this very cycle
  always_comb begin
    wb_clr = '0;
    if (wb_en) wb_clr[wb_rd] = 1'b1;
    busy   = pend_q & ~wb_clr;
    // Illegal words are dropped without looking at their register fields
    hazard = !dec_ill &&
             (busy[dec_rd] || (!dec_li && (busy[dec_rs1] || busy[dec_rs2])));
  end

  assign instr_ready = (!ex_valid_q || ex_ready) && !hazard;
  assign fire        = instr_valid && instr_ready;
  assign issue       = fire && !dec_ill;
  assign rf_we       = wb_en && !(ZERO_R0 && (wb_rd == 3'd0));

  // Operand read: same-cycle writeback bypasses the file, r0 may be hardwired to zero
  always_comb begin
    rs1_val = rf_q[dec_rs1];
    if (wb_en && (wb_rd == dec_rs1)) rs1_val = wb_data;
    if (ZERO_R0 && (dec_rs1 == 3'd0)) rs1_val = '0;
    rs2_val = rf_q[dec_rs2];
    if (wb_en && (wb_rd == dec_rs2)) rs2_val = wb_data;
    if (ZERO_R0 && (dec_rs2 == 3'd0)) rs2_val = '0;
  end

  // Next state of the ex register, scoreboard and illegal pulse
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_ctrl_d  = ex_ctrl_q;
    ex_flag_d  = ex_flag_q;
    ex_rd_d    = ex_rd_q;
    ex_li_d    = ex_li_q;
    ex_imm_d   = ex_imm_q;
    illegal_d  = fire && dec_ill;
    // Clear first so that a same-cycle set on issue wins
    pend_d     = pend_q & ~wb_clr;
    if (issue) begin
      ex_valid_d = 1'b1;
      ex_rd_d    = dec_rd;
      ex_li_d    = dec_li;
      if (dec_li) begin
        ex_rs1_d  = '0;
        ex_rs2_d  = '0;
        ex_ctrl_d = '0;
        ex_flag_d = 1'b0;
        ex_imm_d  = instr[7:0];
      end else begin
        ex_rs1_d  = rs1_val;
        ex_rs2_d  = rs2_val;
        ex_ctrl_d = dec_ctrl;
        ex_flag_d = dec_flag;
        ex_imm_d  = '0;
      end
      if (dec_rd != 3'd0) pend_d[dec_rd] = 1'b1;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // Pipeline and scoreboard registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_ctrl_q  <= '0;
      ex_flag_q  <= 1'b0;
      ex_rd_q    <= '0;
      ex_li_q    <= 1'b0;
      ex_imm_q   <= '0;
      illegal_q  <= 1'b0;
      pend_q     <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_flag_q  <= ex_flag_d;
      ex_rd_q    <= ex_rd_d;
      ex_li_q    <= ex_li_d;
      ex_imm_q   <= ex_imm_d;
      illegal_q  <= illegal_d;
      pend_q     <= pend_d;
    end
  end

  // Register file: writeback lands every cycle it is strobed, independent of stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_rs1   = ex_rs1_q;
  assign ex_rs2   = ex_rs2_q;
  assign ex_ctrl  = ex_ctrl_q;
  assign ex_flag  = ex_flag_q;
  assign ex_rd    = ex_rd_q;
  assign ex_li    = ex_li_q;
  assign ex_imm   = ex_imm_q;
  assign illegal  = illegal_q;

endmodule

// File: doc/id_stage.md
# id_stage

Decode and operand-fetch stage for the Octa16 8-bit datapath. It accepts 16-bit instructions over a valid/ready handshake and decodes them. It holds the 8×8 architectural register file and tracks pending writes with a per-register scoreboard. It presents registered operands (`ex_rs1`, `ex_rs2`, `ex_ctrl`, `ex_flag`) directly to the ALU in the execute stage, and takes the writeback port back from the stage after the ALU.

## Interface
Parameters:
- `ZERO_R0`, default 1: when 1, r0 reads as 8'h00, and writes to r0 are dropped and never scoreboarded.

Ports (clock and reset are fixed: one clock; reset is synchronous and active-high):
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `instr_valid`  in  1  upstream instruction valid
- `instr_ready`  out  1  stage can accept an instruction this cycle
- `instr`  in  16  instruction word
- `ex_valid`  out  1  execute-stage register holds an issued instruction
- `ex_ready`  in  1  execute stage consumes the held instruction this cycle
- `ex_rs1`  out  8  operand A to ALU
- `ex_rs2`  out  8  operand B to ALU
- `ex_ctrl`  out  3  ALU op select
- `ex_flag`  out  1  ALU variant select (SUB/NAND/SLL when 1)
- `ex_rd`  out  3  destination register
- `ex_li`  out  1  load-immediate; execute must write `ex_imm` rather than the ALU result
- `ex_imm`  out  8  immediate for LI
- `wb_en`  in  1  writeback strobe
- `wb_rd`  in  3  writeback register
- `wb_data`  in  8  writeback value
- `illegal`  out  1  one-cycle pulse: illegal opcode was accepted and discarded

## Operation
Instruction encoding:
- ALU ops: `[15:13]`=ctrl, `[12]`=flag, `[11:9]`=rd, `[8:6]`=rs1, `[5:3]`=rs2, `[2:0]` ignored.
- ctrl 000 is ADD/SUB, 001 is NOR/NAND, 010 is SLTU, 011 is SRL/SLL, 100 is SRA.
- ctrl 111 is LI: rd=`[11:9]`, imm=`[7:0]`. There are no sources, `ex_li`=1, and `ex_rs1`/`ex_rs2`/`ex_ctrl`/`ex_flag` are driven 0.
- ctrl 101 and 110 are illegal.

Handshake:
- Transfer occurs when `instr_valid && instr_ready`.
- `instr_ready = (!ex_valid || ex_ready) && !hazard`.
- `instr_ready` depends combinationally on `ex_ready`, `wb_*`, `instr` and state. It never depends on `instr_valid`.

Scoreboard:
- `pend[7:0]` holds one bit per register.
- `hazard` is asserted when any of these hold: a used source register is pending and is not being cleared this cycle; or rd is pending and is not being cleared this cycle (WAW).
- LI uses no sources. Register r0 is never pending.
- A pending bit is cleared when `wb_en` is high for that register.
- A pending bit is set on issue of an instruction to that rd (rd≠0).
- Set and clear of the same register in the same cycle: set wins.

Register read:
- A source equal to `wb_rd` with `wb_en` high reads `wb_data`, bypassing the file in the same cycle.
- Otherwise the source reads the file.
- r0 reads 0 when `ZERO_R0`=1.

Issue and discard:
- An accepted legal instruction loads the ex register and sets `ex_valid`.
- An accepted illegal instruction: the ex register is not loaded, the scoreboard is unchanged, and `illegal`=1 for the next cycle.
- The ex register holds all outputs stable while `ex_valid && !ex_ready`.
- `ex_valid` clears on `ex_ready` when there is no new issue.

Writeback:
- The file is written at the edge whenever `wb_en` is high, regardless of stall.

## Timing
- Reset (asserted at an edge): `ex_valid`, `illegal`, `pend`, all `ex_*` fields and all 8 registers become 0.
- `instr_ready` is 1 in the first cycle after reset.
- `wb_en` during a reset cycle is ignored.
- Reset mid-operation discards the held instruction and all pending state.
- Latency: instruction accepted at edge N appears on `ex_*` with `ex_valid`=1 immediately after edge N, as a 1-cycle stage.
- Full throughput: back-to-back independent instructions issue every cycle while `ex_ready`=1.
- A dependent instruction stalls until the cycle its producer's `wb_en` is high. It issues at that edge with the bypassed value, so the bubble count equals producer writeback latency minus 1.
- Simultaneous `ex_ready` and new issue: the ex register is overwritten and `ex_valid` stays 1.
- Writeback and read of the same register in the same cycle return the new value.

## Test plan
- Reset/LI: after reset, issue LI r1,0x05. Expect `ex_li`=1, `ex_imm`=8'h05, `ex_rd`=1 one cycle later, and `pend[1]`=1. Then drive wb r1=0x05 and expect `pend[1]`=0.
- Bypass: r1 pending. Send ADD r3,r1,r2 (r2=0x03). Expect `instr_ready`=0 until the cycle of wb r1=0x05. Then issue `ex_rs1`=8'h05, `ex_rs2`=8'h03, `ex_ctrl`=000, `ex_flag`=0.
- Backpressure: hold `ex_ready`=0 for 3 cycles with a valid SUB held. Expect `ex_*` stable and `instr_ready`=0. Release and expect the next instruction to issue at the same edge.
- WAW and set-wins: issue to r2 while `wb_en` clears r2 in the same cycle. Expect `pend[2]`=1 afterward. A second write to r2 stalls until the following writeback.
- Illegal/r0: instr 16'hA000 (ctrl 101) gives an `illegal` pulse of exactly one cycle with `ex_valid` unchanged. LI r0,0xFF is never scoreboarded, and r0 reads 8'h00.
- Reset mid-stall: `rst` asserted while a dependent instruction is stalled and `ex_valid`=1. Next cycle: `ex_valid`=0, `pend`=0, `instr_ready`=1.
